mac_acc: RTL and testbench

- Accumulate stage of the MAC processor. Takes signed operand pairs over a valid/ready handshake and drives the sequential `mul` multiplier through its start/ready protocol.
- Sign-extends each 2*OPSIZE product and adds it into a saturating ACCW-bit accumulator.
- Presents the finished sum downstream over a valid/ready handshake after LEN terms, or after a term flagged last.

---
 rtl/mac_acc_if.sv | 33 +++
 rtl/mac_acc.sv | 111 +++++++++++
 tb/tb_mac_acc.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mac_acc_if.sv
// Handshake and multiplier bus bundle for the MAC accumulate stage.
// The slave modport is the accumulator's view; the master modport is the surrounding environment.
interface mac_acc_if #(
    parameter int unsigned OPSIZE = 8,
    parameter int unsigned ACCW   = 20,
    parameter int unsigned CNTW   = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [OPSIZE-1:0]     in_a;
    logic [OPSIZE-1:0]     in_b;
    logic                  in_last;
    logic                  mul_start;
    logic [OPSIZE-1:0]     mul_a;
    logic [OPSIZE-1:0]     mul_b;
    logic [2*OPSIZE-1:0]   mul_out;
    logic                  mul_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACCW-1:0]       out_acc;
    logic                  out_sat;
    logic [CNTW-1:0]       out_count;

    modport slave (
        input  in_valid, in_a, in_b, in_last, mul_out, mul_ready, out_ready,
        output in_ready, mul_start, mul_a, mul_b, out_valid, out_acc, out_sat, out_count
    );

    modport master (
        output in_valid, in_a, in_b, in_last, mul_out, mul_ready, out_ready,
        input  in_ready, mul_start, mul_a, mul_b, out_valid, out_acc, out_sat, out_count
    );
endinterface

// File: rtl/mac_acc.sv
// MAC accumulate stage: drives the sequential multiplier one term at a time and
// saturating-accumulates the products into a result.
module mac_acc #(
    parameter int unsigned OPSIZE = 8,
    parameter int unsigned ACCW   = 20,
    parameter int unsigned LEN    = 4,
    parameter int unsigned CNTW   = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    mac_acc_if.slave bus
);
    localparam int unsigned SW = ACCW + 1;
    localparam logic [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ACCUM, OUTPUT} state_t;

    state_t              state, state_nxt;
    logic [ACCW-1:0]     acc, acc_nxt;
    logic [CNTW-1:0]     count, count_nxt;
    logic                sat, sat_nxt;
    logic [OPSIZE-1:0]   mul_a_r, mul_a_nxt, mul_b_r, mul_b_nxt;
    logic                last_r, last_nxt;
    logic                mul_start_r, out_valid_r;
    logic                in_ready_c;
    logic signed [SW-1:0] sum;

    // Never accept while the multiplier is still busy: it keeps running through our reset.
    assign in_ready_c = (state == IDLE) && bus.mul_ready && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            count       <= '0;
            sat         <= 1'b0;
            mul_a_r     <= '0;
            mul_b_r     <= '0;
            last_r      <= 1'b0;
            mul_start_r <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            count       <= count_nxt;
            sat         <= sat_nxt;
            mul_a_r     <= mul_a_nxt;
            mul_b_r     <= mul_b_nxt;
            last_r      <= last_nxt;
            mul_start_r <= (state_nxt == ISSUE);
            out_valid_r <= (state_nxt == OUTPUT);
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        count_nxt = count;
        sat_nxt   = sat;
        mul_a_nxt = mul_a_r;
        mul_b_nxt = mul_b_r;
        last_nxt  = last_r;
        // One extra bit is enough to see overflow of an in-range acc plus an in-range product.
        sum = SW'(signed'(acc)) + SW'(signed'(bus.mul_out));
        case (state)
            IDLE: begin
                if (bus.in_valid && in_ready_c) begin
                    mul_a_nxt = bus.in_a;
                    mul_b_nxt = bus.in_b;
                    last_nxt  = bus.in_last;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!bus.mul_ready) state_nxt = WAIT_DONE;
            WAIT_DONE: if (bus.mul_ready) state_nxt = ACCUM;
            ACCUM: begin
                if (sum[SW-1] != sum[SW-2]) begin
                    acc_nxt = sum[SW-1] ? ACC_MIN : ACC_MAX;
                    sat_nxt = 1'b1;
                end else begin
                    acc_nxt = sum[ACCW-1:0];
                end
                count_nxt = count + CNTW'(1);
                if (last_r || (LEN != 0 && count_nxt == CNTW'(LEN)))
                    state_nxt = OUTPUT;
                else
                    state_nxt = IDLE;
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    acc_nxt   = '0;
                    count_nxt = '0;
                    sat_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.mul_start = mul_start_r;
    assign bus.mul_a     = mul_a_r;
    assign bus.mul_b     = mul_b_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_acc   = acc;
    assign bus.out_sat   = sat;
    assign bus.out_count = count;
endmodule

// File: tb/tb_mac_acc.sv
// Bench for mac_acc: two instances (ACCW=20/LEN=4 and ACCW=16/LEN=0), each with a
// behavioural sequential multiplier, checked against a queued result scoreboard.
module tb_mac_acc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_acc_if #(.OPSIZE(8), .ACCW(20), .CNTW(8)) if0 ();
    mac_acc_if #(.OPSIZE(8), .ACCW(16), .CNTW(8)) if1 ();

    mac_acc #(.OPSIZE(8), .ACCW(20), .LEN(4), .CNTW(8)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    mac_acc #(.OPSIZE(8), .ACCW(16), .LEN(0), .CNTW(8)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Shared stimulus, steered to one DUT by sel
    int         sel = 0;
    logic       tv = 1'b0, tl = 1'b0;
    logic [7:0] ta = '0, tb_op = '0;
    logic       ordy0 = 1'b1, ordy1 = 1'b1;

    assign if0.in_valid = tv && (sel == 0);
    assign if1.in_valid = tv && (sel == 1);
    assign if0.in_a = ta;    assign if1.in_a = ta;
    assign if0.in_b = tb_op; assign if1.in_b = tb_op;
    assign if0.in_last = tl; assign if1.in_last = tl;
    assign if0.out_ready = ordy0;
    assign if1.out_ready = ordy1;

    // Sequential multiplier models: busy for OPSIZE+1 cycles after start; no reset.
    logic        m0_busy = 1'b0, m1_busy = 1'b0;
    int          m0_cnt = 0, m1_cnt = 0;
    logic [15:0] m0_prod = '0, m1_prod = '0;
    assign if0.mul_ready = !m0_busy;
    assign if1.mul_ready = !m1_busy;
    assign if0.mul_out = m0_prod;
    assign if1.mul_out = m1_prod;

    always @(posedge clk) begin
        if (!m0_busy) begin
            if (if0.mul_start) begin
                m0_busy <= 1'b1; m0_cnt <= 8;
                m0_prod <= 16'($signed(if0.mul_a) * $signed(if0.mul_b));
            end
        end else if (m0_cnt == 0) m0_busy <= 1'b0;
        else m0_cnt <= m0_cnt - 1;
        if (!m1_busy) begin
            if (if1.mul_start) begin
                m1_busy <= 1'b1; m1_cnt <= 8;
                m1_prod <= 16'($signed(if1.mul_a) * $signed(if1.mul_b));
            end
        end else if (m1_cnt == 0) m1_busy <= 1'b0;
        else m1_cnt <= m1_cnt - 1;
    end

    typedef struct { longint acc; bit sat; int cnt; } exp_t;
    exp_t   q0[$], q1[$];
    longint acc_m[2];
    bit     sat_m[2];
    int     cnt_m[2];
    int     starts0 = 0;

    task automatic model_clear(input int s);
        acc_m[s] = 0; sat_m[s] = 0; cnt_m[s] = 0;
    endtask

    task automatic model_term(input int s, input int a, input int b, input bit last);
        int     accw = (s == 0) ? 20 : 16;
        int     len  = (s == 0) ? 4 : 0;
        longint mx = (longint'(1) << (accw - 1)) - 1;
        longint mn = -(longint'(1) << (accw - 1));
        exp_t   e;
        acc_m[s] = acc_m[s] + longint'(a) * longint'(b);
        if (acc_m[s] > mx) begin acc_m[s] = mx; sat_m[s] = 1; end
        if (acc_m[s] < mn) begin acc_m[s] = mn; sat_m[s] = 1; end
        cnt_m[s] = (cnt_m[s] + 1) % 256;
        if (last || (len != 0 && cnt_m[s] == len)) begin
            e.acc = acc_m[s]; e.sat = sat_m[s]; e.cnt = cnt_m[s];
            if (s == 0) q0.push_back(e); else q1.push_back(e);
            model_clear(s);
        end
    endtask

    task automatic send(input int s, input int a, input int b, input bit last);
        int n = 0;
        @(negedge clk);
        while (!((s == 0) ? if0.in_ready : if1.in_ready) && n < 500) begin
            @(negedge clk); n++;
        end
        if (n >= 500) check("send_timeout", 0, 1);
        sel = s; ta = 8'(a); tb_op = 8'(b); tl = last; tv = 1'b1;
        model_term(s, a, b, last);
        @(posedge clk);
        #1 tv = 1'b0; tl = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 3000) begin
            @(negedge clk); n++;
        end
        if (n >= 3000) check("drain_timeout", longint'(q0.size() + q1.size()), 0);
    endtask

    // Scoreboard and start-pulse monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (if0.out_valid && if0.out_ready) begin
                if (q0.size() == 0) check("sb0_unexpected", 1, 0);
                else begin
                    e = q0.pop_front();
                    check("sb0_acc", longint'($signed(if0.out_acc)), e.acc);
                    check("sb0_sat", longint'(if0.out_sat), longint'(e.sat));
                    check("sb0_cnt", longint'(if0.out_count), longint'(e.cnt));
                end
            end
            if (if1.out_valid && if1.out_ready) begin
                if (q1.size() == 0) check("sb1_unexpected", 1, 0);
                else begin
                    e = q1.pop_front();
                    check("sb1_acc", longint'($signed(if1.out_acc)), e.acc);
                    check("sb1_sat", longint'(if1.out_sat), longint'(e.sat));
                    check("sb1_cnt", longint'(if1.out_count), longint'(e.cnt));
                end
            end
            if (if0.mul_start) begin
                starts0++;
                check("start0_mul_idle", longint'(if0.mul_ready), 1);
            end
            if (if1.mul_start) check("start1_mul_idle", longint'(if1.mul_ready), 1);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  longint'(if0.in_ready), 0);
        check({tag, "_out_valid"}, longint'(if0.out_valid), 0);
        check({tag, "_mul_start"}, longint'(if0.mul_start), 0);
        check({tag, "_mul_a"},     longint'(if0.mul_a), 0);
        check({tag, "_mul_b"},     longint'(if0.mul_b), 0);
        check({tag, "_acc"},       longint'(if0.out_acc), 0);
        check({tag, "_cnt"},       longint'(if0.out_count), 0);
        check({tag, "_sat"},       longint'(if0.out_sat), 0);
    endtask

    initial begin
        int s_before, n;
        model_clear(0); model_clear(1);
        #1 check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("por_in_ready_up", longint'(if0.in_ready), 1);

        // Four-term result, out_ready already high
        s_before = starts0;
        send(0, 3, 5, 0); send(0, -2, 7, 0); send(0, 4, -4, 0); send(0, -6, -6, 0);
        drain();
        check("len4_starts", longint'(starts0 - s_before), 4);

        // Backpressure: hold result for 10 cycles
        ordy0 = 1'b0;
        send(0, 1, 1, 0); send(0, 2, 2, 0); send(0, 3, 3, 0); send(0, -1, 5, 0);
        n = 0;
        while (!if0.out_valid && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("bp_valid_timeout", 0, 1);
        repeat (10) begin
            @(negedge clk);
            check("bp_valid", longint'(if0.out_valid), 1);
            check("bp_in_ready", longint'(if0.in_ready), 0);
            check("bp_acc", longint'($signed(if0.out_acc)), 9);
            check("bp_cnt", longint'(if0.out_count), 4);
        end
        @(posedge clk); #1 ordy0 = 1'b1;
        @(posedge clk); #1 ordy0 = 1'b0;
        @(negedge clk);
        check("bp_valid_drop", longint'(if0.out_valid), 0);
        check("bp_acc_clear", longint'(if0.out_acc), 0);
        ordy0 = 1'b1;
        drain();

        // Early termination on in_last
        send(0, 10, 10, 0); send(0, -1, 1, 1);
        drain();

        // Saturation on the narrow, unbounded instance
        send(1, -128, -128, 0); send(1, -128, -128, 0); send(1, -128, 127, 1);
        drain();

        // LEN=0 counter wrap: 256 zero terms then a closing term -> count wraps to 1
        for (int i = 0; i < 256; i++) send(1, 0, 0, 0);
        send(1, 1, 1, 1);
        drain();

        // Reset during WAIT_DONE discards the in-flight term
        send(0, 3, 5, 0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        model_clear(0);
        #1 check_reset_outputs("mid");
        check("mid_mul_busy", longint'(if0.mul_ready), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        if (!if0.mul_ready) check("mid_in_ready_held", longint'(if0.in_ready), 0);
        n = 0;
        while (!if0.mul_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("mid_ready_timeout", 0, 1);
        check("mid_in_ready_up", longint'(if0.in_ready), 1);
        send(0, 2, 3, 1);
        drain();

        repeat (5) @(posedge clk);
        check("q_empty", longint'(q0.size() + q1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
